// File: rtl/serial_mod_checker.sv
// serial_mod_checker: tracks the running remainder of a serially received
// unsigned number modulo DIVISOR. The stream may be MSB-first or LSB-first,
// may contain gaps (din_valid=0), and may be restarted with start.
module serial_mod_checker #(
  parameter int unsigned DIVISOR   = 3,
  parameter bit          LSB_FIRST = 1'b0,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned RW       = (DIVISOR > 2) ? $clog2(DIVISOR) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             din,
  input  logic             din_valid,
  input  logic             start,
  output logic             dout,
  output logic             dout_valid,
  output logic [RW-1:0]    rem,
  output logic [CNT_W-1:0] bit_count
);

  if (DIVISOR < 2 || DIVISOR > 65535) begin : g_bad_divisor
    $error("serial_mod_checker: DIVISOR must be in 2..65535");
  end

  // Divisor at the width of the pre-reduction sum; every intermediate is
  // below 2*DIVISOR, so one compare/subtract is a full modulo reduction.
  localparam logic [RW:0] DIV_V = DIVISOR[RW:0];

  logic [RW-1:0]    rem_q, rem_d;
  logic [RW-1:0]    weight_q, weight_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic [CNT_W-1:0] bit_count_q, bit_count_d;

  logic [RW-1:0]    r_b, w_b;
  logic [CNT_W-1:0] c_b;
  logic [RW:0]      t, w2;

  // Next-state datapath: absorb one bit when qualified, otherwise hold.
  always_comb begin
    rem_d        = rem_q;
    weight_d     = weight_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    bit_count_d  = bit_count_q;

    // A restart behaves as if the previous number were empty.
    r_b = start ? '0 : rem_q;
    w_b = start ? RW'(1) : weight_q;
    c_b = start ? '0 : bit_count_q;

    if (LSB_FIRST) begin
      t  = {1'b0, r_b} + (din ? {1'b0, w_b} : '0);
      w2 = {w_b, 1'b0};
    end else begin
      t  = {r_b, din};
      w2 = '0;
    end

    if (din_valid) begin
      rem_d        = RW'((t >= DIV_V) ? (t - DIV_V) : t);
      weight_d     = LSB_FIRST ? RW'((w2 >= DIV_V) ? (w2 - DIV_V) : w2) : RW'(1);
      dout_d       = (rem_d == '0);
      dout_valid_d = 1'b1;
      bit_count_d  = (c_b == '1) ? c_b : c_b + CNT_W'(1);
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rem_q        <= '0;
      weight_q     <= RW'(1);
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      bit_count_q  <= '0;
    end else begin
      rem_q        <= rem_d;
      weight_q     <= weight_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      bit_count_q  <= bit_count_d;
    end
  end

  assign rem        = rem_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign bit_count  = bit_count_q;

endmodule

// File: tb/tb_serial_mod_checker.sv
// Bench for serial_mod_checker: four instances with different parameters,
// a stimulus table of {inputs, expected outputs}, and a randomised
// MSB-first run against a wide-integer reference value.
module tb_serial_mod_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Per-instance inputs: 0 = /3 MSB, 1 = /5 MSB, 2 = /3 LSB, 3 = /7 MSB CNT_W=4
  logic rstn_a [4];
  logic vld_a  [4];
  logic st_a   [4];
  logic din_a  [4];

  logic        dout_o [4];
  logic        dv_o   [4];
  logic [15:0] rem_o  [4];
  logic [15:0] cnt_o  [4];

  logic [1:0]  rem0, rem2;
  logic [2:0]  rem1, rem3;
  logic [15:0] cnt0, cnt1, cnt2;
  logic [3:0]  cnt3;

  serial_mod_checker #(.DIVISOR(3), .LSB_FIRST(1'b0), .CNT_W(16)) u0 (
    .clk(clk), .resetn(rstn_a[0]), .din(din_a[0]), .din_valid(vld_a[0]), .start(st_a[0]),
    .dout(dout_o[0]), .dout_valid(dv_o[0]), .rem(rem0), .bit_count(cnt0));
  serial_mod_checker #(.DIVISOR(5), .LSB_FIRST(1'b0), .CNT_W(16)) u1 (
    .clk(clk), .resetn(rstn_a[1]), .din(din_a[1]), .din_valid(vld_a[1]), .start(st_a[1]),
    .dout(dout_o[1]), .dout_valid(dv_o[1]), .rem(rem1), .bit_count(cnt1));
  serial_mod_checker #(.DIVISOR(3), .LSB_FIRST(1'b1), .CNT_W(16)) u2 (
    .clk(clk), .resetn(rstn_a[2]), .din(din_a[2]), .din_valid(vld_a[2]), .start(st_a[2]),
    .dout(dout_o[2]), .dout_valid(dv_o[2]), .rem(rem2), .bit_count(cnt2));
  serial_mod_checker #(.DIVISOR(7), .LSB_FIRST(1'b0), .CNT_W(4)) u3 (
    .clk(clk), .resetn(rstn_a[3]), .din(din_a[3]), .din_valid(vld_a[3]), .start(st_a[3]),
    .dout(dout_o[3]), .dout_valid(dv_o[3]), .rem(rem3), .bit_count(cnt3));

  assign rem_o[0] = {14'd0, rem0};
  assign rem_o[1] = {13'd0, rem1};
  assign rem_o[2] = {14'd0, rem2};
  assign rem_o[3] = {13'd0, rem3};
  assign cnt_o[0] = cnt0;
  assign cnt_o[1] = cnt1;
  assign cnt_o[2] = cnt2;
  assign cnt_o[3] = {12'd0, cnt3};

  typedef struct {
    int   k;
    logic rn, v, s, d;
    int   er;
    logic ed, edv;
    int   ec;
  } vec_t;

  typedef struct {
    int   k;
    int   step;
    int   er;
    logic ed, edv;
    int   ec;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   step_no = 0;

  function automatic void add(input int k, input logic rn, v, s, d,
                              input int er, input logic ed, edv, input int ec);
    vec_t e;
    e.k = k; e.rn = rn; e.v = v; e.s = s; e.d = d;
    e.er = er; e.ed = ed; e.edv = edv; e.ec = ec;
    tbl.push_back(e);
  endfunction

  task automatic check(input string name, input int step, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s step %0d: got %0d, expected %0d", name, step, act, req);
    end
  endtask

  task automatic set_idle();
    for (int i = 0; i < 4; i++) begin
      rstn_a[i] = 1'b1; vld_a[i] = 1'b0; st_a[i] = 1'b0; din_a[i] = 1'b0;
    end
  endtask

  // Drive one cycle of stimulus into instance k, queue its expected
  // result, and compare once the clock edge has produced it.
  task automatic step(input int k, input logic rn, v, s, d,
                      input int er, input logic ed, edv, input int ec);
    exp_t x;
    exp_t got;
    @(negedge clk);
    set_idle();
    rstn_a[k] = rn; vld_a[k] = v; st_a[k] = s; din_a[k] = d;
    step_no++;
    x.k = k; x.step = step_no; x.er = er; x.ed = ed; x.edv = edv; x.ec = ec;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard step %0d: queue empty, expected one entry", step_no);
    end else begin
      got = sb.pop_front();
      check("rem",        got.step, int'(rem_o[got.k]),  got.er);
      check("dout",       got.step, int'(dout_o[got.k]), int'(got.ed));
      check("dout_valid", got.step, int'(dv_o[got.k]),   int'(got.edv));
      check("bit_count",  got.step, int'(cnt_o[got.k]),  got.ec);
    end
  endtask

  initial begin : main
    logic [63:0] val;
    int          nb;
    logic        b;
    int          r;

    set_idle();
    for (int i = 0; i < 4; i++) rstn_a[i] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset_rem",  i, int'(rem_o[i]),  0);
      check("reset_dout", i, int'(dout_o[i]), 0);
      check("reset_dv",   i, int'(dv_o[i]),   0);
      check("reset_cnt",  i, int'(cnt_o[i]),  0);
    end

    //  k  rn v  s  d    rem dout dv cnt
    // /3 MSB: 1,1,0 -> values 1,3,6
    add(0, 1, 1, 0, 1,   1, 0, 1, 1);
    add(0, 1, 1, 0, 1,   0, 1, 1, 2);
    add(0, 1, 1, 0, 0,   0, 1, 1, 3);
    // /5 MSB: 1,0, three-cycle gap, 1,0 -> values 1,2,5,10
    add(1, 1, 1, 0, 1,   1, 0, 1, 1);
    add(1, 1, 1, 0, 0,   2, 0, 1, 2);
    add(1, 1, 0, 0, 1,   2, 0, 1, 2);
    add(1, 1, 0, 1, 1,   2, 0, 1, 2);
    add(1, 1, 0, 0, 0,   2, 0, 1, 2);
    add(1, 1, 1, 0, 1,   0, 1, 1, 3);
    add(1, 1, 1, 0, 0,   0, 1, 1, 4);
    // /3 LSB: 1,1,0,1 -> partial values 1,3,3,11
    add(2, 1, 1, 0, 1,   1, 0, 1, 1);
    add(2, 1, 1, 0, 1,   0, 1, 1, 2);
    add(2, 1, 1, 0, 0,   0, 1, 1, 3);
    add(2, 1, 1, 0, 1,   2, 0, 1, 4);
    // /3 MSB restart: start with din=1 after value 6; unqualified start ignored
    add(0, 1, 1, 1, 1,   1, 0, 1, 1);
    add(0, 1, 1, 0, 0,   2, 0, 1, 2);
    add(0, 1, 0, 1, 1,   2, 0, 1, 2);
    add(0, 1, 1, 1, 1,   1, 0, 1, 1);
    // build 1,0,1,1,1 = 23 -> rem 2 at bit_count 5, then reset mid-number
    add(0, 1, 1, 0, 0,   2, 0, 1, 2);
    add(0, 1, 1, 0, 1,   2, 0, 1, 3);
    add(0, 1, 1, 0, 1,   2, 0, 1, 4);
    add(0, 1, 1, 0, 1,   2, 0, 1, 5);
    add(0, 0, 1, 1, 1,   0, 0, 0, 0);
    add(0, 1, 1, 0, 0,   0, 1, 1, 1);
    // start on the first bit after reset is the same as no start
    add(0, 0, 0, 0, 0,   0, 0, 0, 0);
    add(0, 1, 1, 1, 1,   1, 0, 1, 1);
    // LSB restart: weight must return to 1
    add(2, 1, 1, 1, 1,   1, 0, 1, 1);
    add(2, 1, 1, 0, 0,   1, 0, 1, 2);
    add(2, 1, 1, 0, 1,   2, 0, 1, 3);

    foreach (tbl[i])
      step(tbl[i].k, tbl[i].rn, tbl[i].v, tbl[i].s, tbl[i].d,
           tbl[i].er, tbl[i].ed, tbl[i].edv, tbl[i].ec);

    // /7 MSB with a 4-bit counter: 20 random bits, counter saturates at 15
    val = 64'd0;
    nb  = 0;
    for (int i = 0; i < 20; i++) begin
      b   = 1'($urandom_range(0, 1));
      val = (val << 1) | {63'd0, b};
      nb++;
      r = int'(val % 64'd7);
      step(3, 1'b1, 1'b1, (i == 0), b, r, (r == 0), 1'b1, (nb > 15) ? 15 : nb);
    end
    // gap after saturation holds everything
    step(3, 1'b1, 1'b0, 1'b0, 1'b1, r, (r == 0), 1'b1, 15);

    @(negedge clk);
    set_idle();
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_mod_checker.md
Name: serial_mod_checker

Overview:
- Parametrised successor to the team's fixed divide-by-3 serial detector.
- Tracks the running remainder of a serially received unsigned number modulo DIVISOR, one bit per qualified cycle.
- Reports divisibility, the remainder and a saturating bit count. Supports MSB-first or LSB-first bit order, input gaps (valid qualifier) and explicit number restart.
- Sits after a serial deserialiser/bit-stream source in checksum and framing logic.

Parameters:
- DIVISOR, 3, modulus; legal range 2..65535; elaboration error outside range.
- LSB_FIRST, 0, 0 = MSB-first stream, 1 = LSB-first stream.
- CNT_W, 16, width of bit_count.
- Derived localparam RW = $clog2(DIVISOR) (minimum 1); not user-settable.

Ports:
- clk, in, 1, rising-edge clock.
- resetn, in, 1, synchronous active-low reset.
- din, in, 1, serial data bit.
- din_valid, in, 1, din qualifier; bit absorbed only when 1.
- start, in, 1, marks din as first bit of a new number; honoured only with din_valid=1.
- dout, out, 1, registered: current number divisible by DIVISOR.
- dout_valid, out, 1, at least one bit absorbed since reset.
- rem, out, RW, registered running remainder (0..DIVISOR-1).
- bit_count, out, CNT_W, bits absorbed in current number; saturates at all-ones.

Behaviour:
- Reset (resetn=0 at posedge): rem=0, weight=1, dout=0, dout_valid=0, bit_count=0. Reset wins over every other input. Reset mid-number discards all state.
- din_valid=0: all registers hold. start is ignored.
- Base values when din_valid=1:
  - r_b = start ? 0 : rem
  - w_b = start ? 1 : weight
  - c_b = start ? 0 : bit_count
- MSB-first update (LSB_FIRST=0):
  - t = 2*r_b + din (RW+1 bits; t < 2*DIVISOR)
  - rem_next = (t >= DIVISOR) ? t-DIVISOR : t
  - weight register unused; tie to 1.
- LSB-first update (LSB_FIRST=1):
  - t = r_b + (din ? w_b : 0)
  - rem_next = one conditional subtract of DIVISOR
  - weight_next = (2*w_b) mod DIVISOR, one conditional subtract
- Arithmetic: no multipliers or dividers; every mod is a single compare/subtract since operands are < 2*DIVISOR.
- Outputs on an absorbed bit:
  - dout <= (rem_next == 0)
  - dout_valid <= 1
  - bit_count <= saturating c_b+1
- Latency: one cycle from a qualified bit to updated dout/rem/bit_count. All outputs come straight from registers, with no combinational path from inputs.
- A leading zero bit gives value 0, so dout=1. This matches the legacy divide-by-3 behaviour.
- start with din_valid=1 on the first cycle after reset behaves identically to no start.
- DIVISOR a power of two needs no special-casing; the generic datapath handles it.
- bit_count saturates at 2^CNT_W-1 and holds. The remainder continues updating correctly past saturation.

Test Plan:
- DIVISOR=3, MSB-first, bits 1,1,0 (values 1,3,6) -> rem 1,0,0; dout 0,1,1; bit_count 1,2,3; each one cycle after the bit.
- DIVISOR=5, MSB-first, bits 1,0,1,0 (values 1,2,5,10) -> rem 1,2,0,0; dout 0,0,1,1. Insert din_valid=0 for 3 cycles after bit 2 -> outputs hold at rem=2, dout=0 through the gap.
- DIVISOR=3, LSB_FIRST=1, bits 1,1,0,1 (value 11) -> rem 1,0,0,2; dout 0,1,1,0.
- DIVISOR=3, MSB-first, bits 1,0 (rem=2), then start=1 with din=1 -> rem=1, dout=0, bit_count=1. Also drive start=1 with din_valid=0 -> no change.
- Assert resetn=0 mid-number (rem=2, bit_count=5) -> next cycle rem=0, dout=0, dout_valid=0, bit_count=0. First bit after reset is 0 -> dout=1, dout_valid=1.
- CNT_W=4, DIVISOR=7, 20 random MSB-first bits -> bit_count stops at 15; rem and dout match a reference model (value mod 7) on every bit.
